// File: rtl/mix_pkg.sv
// Shared types and constants for the quad motor mixer scheduler.
package mix_pkg;

    localparam int unsigned ACC_W = 11;
    localparam int unsigned CMD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MOTOR_FL = 2'd0;
    localparam logic [1:0] MOTOR_FR = 2'd1;
    localparam logic [1:0] MOTOR_RR = 2'd2;
    localparam logic [1:0] MOTOR_RL = 2'd3;

    // MIX_SIGN[motor][axis]: axis 0=pitch, 1=roll, 2=yaw; a set bit subtracts the term.
    localparam logic [3:0][2:0] MIX_SIGN = {
        3'b001,  // rear-left:   -P +R +Y
        3'b111,  // rear-right:  -P -R -Y
        3'b010,  // front-right: +P -R +Y
        3'b100   // front-left:  +P +R -Y
    };

    typedef struct packed {
        logic [CMD_W-1:0] thr;
        logic [CMD_W-1:0] pitch;
        logic [CMD_W-1:0] roll;
        logic [CMD_W-1:0] yaw;
        logic             armed;
    } frame_t;

endpackage

// File: rtl/offset_mix_alu.sv
// Shared mixer datapath: load or +/- accumulate one axis term, then clamp and arm-gate.
module offset_mix_alu
    import mix_pkg::*;
#(
    parameter logic [CMD_W-1:0] MIN_CMD = 8'd10,
    parameter logic [CMD_W-1:0] MAX_CMD = 8'd250
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic        [CMD_W-1:0] operand_i,
    input  logic                    load_i,
    input  logic                    sub_i,
    input  logic                    armed_i,
    output logic signed [ACC_W-1:0] acc_c_o,
    output logic        [CMD_W-1:0] cmd_c_o
);

    localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(MIN_CMD);
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX_CMD);

    logic signed [ACC_W-1:0] opnd_s;

    always_comb begin
        opnd_s  = ACC_W'($signed(operand_i));
        acc_c_o = '0;
        cmd_c_o = '0;
        if (load_i) begin
            acc_c_o = ACC_W'(operand_i);
        end else if (sub_i) begin
            acc_c_o = acc_i - opnd_s;
        end else begin
            acc_c_o = acc_i + opnd_s;
        end
        if (!armed_i) begin
            cmd_c_o = '0;
        end else if (acc_c_o < MIN_S) begin
            cmd_c_o = MIN_CMD;
        end else if (acc_c_o > MAX_S) begin
            cmd_c_o = MAX_CMD;
        end else begin
            cmd_c_o = acc_c_o[CMD_W-1:0];
        end
    end

endmodule

// File: rtl/offset_mix_scheduler.sv
// Sequences the shared mixer ALU over 16 motor x axis steps per frame and publishes four motor commands.
module offset_mix_scheduler
    import mix_pkg::*;
#(
    parameter logic [7:0] MIN_CMD = 8'd10,
    parameter logic [7:0] MAX_CMD = 8'd250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid,
    input  logic [7:0] throttle_offset,
    input  logic [7:0] pitch_offset,
    input  logic [7:0] roll_offset,
    input  logic [7:0] yaw_offset,
    input  logic       armed,
    output logic [7:0] motor_1_cmd,
    output logic [7:0] motor_2_cmd,
    output logic [7:0] motor_3_cmd,
    output logic [7:0] motor_4_cmd,
    output logic       cmd_valid,
    output logic       busy,
    output logic       overrun
);

    state_t                  state_q, state_d;
    logic [3:0]              step_q, step_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    frame_t                  work_q, work_d;
    frame_t                  pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [3:0][CMD_W-1:0]   stage_q, stage_d;
    logic [3:0][CMD_W-1:0]   cmd_q, cmd_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    frame_t                  in_frame;
    logic [1:0]              motor, axis;
    logic [2:0]              sign_row;
    logic [CMD_W-1:0]        operand;
    logic                    alu_sub;
    logic signed [ACC_W-1:0] alu_acc;
    logic [CMD_W-1:0]        alu_cmd;

    assign in_frame = '{thr: throttle_offset, pitch: pitch_offset, roll: roll_offset,
                        yaw: yaw_offset, armed: armed};
    assign motor    = step_q[3:2];
    assign axis     = step_q[1:0];
    assign sign_row = MIX_SIGN[motor];

    // Operand and add/subtract select for the current step.
    always_comb begin
        operand = work_q.thr;
        alu_sub = 1'b0;
        case (axis)
            2'd1: begin operand = work_q.pitch; alu_sub = sign_row[0]; end
            2'd2: begin operand = work_q.roll;  alu_sub = sign_row[1]; end
            2'd3: begin operand = work_q.yaw;   alu_sub = sign_row[2]; end
            default: begin operand = work_q.thr; alu_sub = 1'b0; end
        endcase
    end

    offset_mix_alu #(
        .MIN_CMD (MIN_CMD),
        .MAX_CMD (MAX_CMD)
    ) u_alu (
        .acc_i     (acc_q),
        .operand_i (operand),
        .load_i    (axis == 2'd0),
        .sub_i     (alu_sub),
        .armed_i   (work_q.armed),
        .acc_c_o   (alu_acc),
        .cmd_c_o   (alu_cmd)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        work_d      = work_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        stage_d     = stage_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                step_d = '0;
                if (frame_valid) begin
                    work_d  = in_frame;
                    state_d = MIX;
                end
            end
            MIX: begin
                acc_d  = alu_acc;
                step_d = 4'(step_q + 4'd1);
                if (axis == 2'd3) begin
                    stage_d[motor] = alu_cmd;
                end
                if (step_q == 4'd15) begin
                    state_d = DONE;
                end
                if (frame_valid) begin
                    pend_d     = in_frame;
                    pend_vld_d = 1'b1;
                    overrun_d  = pend_vld_q;
                end
            end
            DONE: begin
                cmd_d       = stage_q;
                cmd_valid_d = 1'b1;
                step_d      = '0;
                // A frame arriving here either chains straight into MIX or refills pending.
                if (pend_vld_q) begin
                    work_d  = pend_q;
                    state_d = MIX;
                    if (frame_valid) begin
                        pend_d = in_frame;
                    end else begin
                        pend_vld_d = 1'b0;
                    end
                end else if (frame_valid) begin
                    work_d  = in_frame;
                    state_d = MIX;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            acc_q       <= '0;
            work_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            stage_q     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            work_q      <= work_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            stage_q     <= stage_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign motor_1_cmd = cmd_q[MOTOR_FL];
    assign motor_2_cmd = cmd_q[MOTOR_FR];
    assign motor_3_cmd = cmd_q[MOTOR_RR];
    assign motor_4_cmd = cmd_q[MOTOR_RL];
    assign cmd_valid   = cmd_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_offset_mix_scheduler.sv
// Scoreboard bench for offset_mix_scheduler: directed frames, decoupled output monitor.
module tb_offset_mix_scheduler;

    logic       clk;
    logic       rst;
    logic       frame_valid;
    logic [7:0] throttle_offset, pitch_offset, roll_offset, yaw_offset;
    logic       armed;
    logic [7:0] motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd;
    logic       cmd_valid, busy, overrun;

    offset_mix_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .frame_valid     (frame_valid),
        .throttle_offset (throttle_offset),
        .pitch_offset    (pitch_offset),
        .roll_offset     (roll_offset),
        .yaw_offset      (yaw_offset),
        .armed           (armed),
        .motor_1_cmd     (motor_1_cmd),
        .motor_2_cmd     (motor_2_cmd),
        .motor_3_cmd     (motor_3_cmd),
        .motor_4_cmd     (motor_4_cmd),
        .cmd_valid       (cmd_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    typedef struct {
        logic [7:0] m1, m2, m3, m4;
        int         at;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every cmd_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_cmd_valid: got pulse expected none (edge %0d)", edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_m1"}, int'(motor_1_cmd), int'(e.m1));
                check({e.tag, "_m2"}, int'(motor_2_cmd), int'(e.m2));
                check({e.tag, "_m3"}, int'(motor_3_cmd), int'(e.m3));
                check({e.tag, "_m4"}, int'(motor_4_cmd), int'(e.m4));
                check({e.tag, "_latency"}, edge_cnt, e.at);
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the acceptance edge count.
    task automatic drive_frame(input logic [7:0] t, input logic [7:0] p, input logic [7:0] r,
                               input logic [7:0] y, input logic arm, output int acc_cnt);
        frame_valid     = 1'b1;
        throttle_offset = t;
        pitch_offset    = p;
        roll_offset     = r;
        yaw_offset      = y;
        armed           = arm;
        @(negedge clk);
        acc_cnt     = edge_cnt;
        frame_valid = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input int at);
        exp_t e;
        e.m1 = a; e.m2 = b; e.m3 = c; e.m4 = d; e.at = at; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_negedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a, b, c, n;
        rst = 1'b1; frame_valid = 1'b0; armed = 1'b0;
        throttle_offset = '0; pitch_offset = '0; roll_offset = '0; yaw_offset = '0;
        wait_negedges(3);
        rst = 1'b0;
        wait_negedges(1);
        check("reset_m1", int'(motor_1_cmd), 0);
        check("reset_m4", int'(motor_4_cmd), 0);
        check("reset_cmd_valid", int'(cmd_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);

        // Zero-attitude baseline plus busy length.
        drive_frame(8'd100, 8'd0, 8'd0, 8'd0, 1'b1, a);
        push_exp("baseline", 8'd100, 8'd100, 8'd100, 8'd100, a + 17);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        check("busy_len", n, 17);
        drain("baseline");

        drive_frame(8'd100, 8'd20, 8'd0, 8'd0, 1'b1, a);
        push_exp("pitch", 8'd120, 8'd120, 8'd80, 8'd80, a + 17);
        drain("pitch");
        check("hold_m3", int'(motor_3_cmd), 80);
        check("hold_cmd_valid_low", int'(cmd_valid), 0);

        drive_frame(8'd240, 8'd127, 8'd127, 8'h80, 1'b1, a);
        push_exp("saturate", 8'd250, 8'd112, 8'd114, 8'd112, a + 17);
        drain("saturate");

        drive_frame(8'd0, 8'hCE, 8'd0, 8'd0, 1'b1, a);
        push_exp("low_clamp", 8'd10, 8'd10, 8'd50, 8'd50, a + 17);
        drain("low_clamp");

        drive_frame(8'd0, 8'hCE, 8'd0, 8'd0, 1'b0, a);
        push_exp("disarmed", 8'd0, 8'd0, 8'd0, 8'd0, a + 17);
        drain("disarmed");

        // Back-to-back: A at cycle 0, B at 5, C at 9; B is dropped by the overrun.
        drive_frame(8'd150, 8'd0, 8'd0, 8'd5, 1'b1, a);
        push_exp("chain_a", 8'd145, 8'd155, 8'd145, 8'd155, a + 17);
        wait_negedges(4);
        drive_frame(8'd200, 8'd0, 8'd0, 8'd0, 1'b1, b);
        check("b2b_b_no_overrun", int'(overrun), 0);
        check("b2b_b_spacing", b - a, 5);
        wait_negedges(3);
        drive_frame(8'd50, 8'd0, 8'd10, 8'd0, 1'b1, c);
        check("b2b_c_overrun", int'(overrun), 1);
        check("b2b_c_spacing", c - a, 9);
        push_exp("chain_c", 8'd60, 8'd40, 8'd40, 8'd60, a + 34);
        wait_negedges(1);
        check("overrun_one_cycle", int'(overrun), 0);
        drain("chain");
        check("chain_idle", int'(busy), 0);

        // Reset on the 8th MIX edge aborts the frame; coincident frame_valid is ignored.
        drive_frame(8'd30, 8'd0, 8'd0, 8'd0, 1'b1, a);
        wait_negedges(7);
        rst = 1'b1;
        frame_valid = 1'b1;
        throttle_offset = 8'd99;
        wait_negedges(1);
        rst = 1'b0;
        frame_valid = 1'b0;
        check("abort_m1", int'(motor_1_cmd), 0);
        check("abort_m2", int'(motor_2_cmd), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_cmd_valid", int'(cmd_valid), 0);
        wait_negedges(25);
        check("abort_still_idle", int'(busy), 0);

        drive_frame(8'd77, 8'd0, 8'd0, 8'd0, 1'b1, a);
        push_exp("post_reset", 8'd77, 8'd77, 8'd77, 8'd77, a + 17);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/offset_mix_scheduler.md
# offset_mix_scheduler

Time-multiplexed motor mixer controller for the quad. It accepts one frame of throttle, pitch, roll and yaw receiver offsets and sequences a single shared add/subtract/clamp datapath over the 16 motor×axis terms. It then publishes four clamped 8-bit motor commands with a one-cycle valid pulse. It sits between the receiver offset generators and the motor PWM drivers, and replaces four parallel adder trees with one scheduled ALU.

## Interface
Parameters:
- MIN_CMD, 8'd10, lower clamp for an armed motor command
- MAX_CMD, 8'd250, upper clamp for a motor command (MIN_CMD < MAX_CMD)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; **synchronous, active-high**
- frame_valid  in  1  one-cycle strobe; offsets and armed are valid this cycle
- throttle_offset  in  8  unsigned throttle
- pitch_offset  in  8  signed two's-complement pitch
- roll_offset  in  8  signed two's-complement roll
- yaw_offset  in  8  signed two's-complement yaw
- armed  in  1  sampled with the frame; 0 forces all commands to 0
- motor_1_cmd .. motor_4_cmd  out  8 each  registered motor commands
- cmd_valid  out  1  one-cycle pulse when the four motor_N_cmd outputs update
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  one-cycle pulse when a pending frame is overwritten

## Operation
- States:
  - IDLE: frame_valid → snapshot the inputs into the work registers, go to MIX.
  - MIX: 16 steps, step counter s = {motor m[1:0], axis a[1:0]}, one step per cycle.
  - DONE: one cycle.
- MIX step:
  - a=0: acc = zero-extended throttle.
  - a=1..3: acc = acc ± sign-extended pitch, roll or yaw.
  - acc is 11-bit signed. The worst case is −384..+639, so there is no overflow.
- Sign matrix (P, R, Y):
  - M1 front-left: +P +R −Y
  - M2 front-right: +P −R +Y
  - M3 rear-right: −P −R −Y
  - M4 rear-left: −P +R +Y
- On a=3 the result is clamped and written to staging register m:
  - if disarmed: 0
  - else if acc < MIN_CMD: MIN_CMD
  - else if acc > MAX_CMD: MAX_CMD
  - else acc[7:0]
- DONE:
  - Copy all four staging registers to motor_N_cmd simultaneously and assert cmd_valid.
  - If pending is set: move the pending snapshot into the work registers, clear pending, go to MIX with no IDLE cycle.
  - Otherwise go to IDLE.
- frame_valid while busy (MIX or DONE):
  - Capture the inputs into a one-deep pending buffer, newest wins.
  - If pending was already full, pulse overrun; the older pending frame is dropped.
  - DONE with pending full and a new frame_valid: the old pending frame goes to work, the new one goes to pending, and there is no overrun.
- Outputs hold their last values between frames. A frame in progress never alters the outputs until DONE.

## Timing
- frame_valid sampled high at edge T (IDLE) → MIX occupies edges T+1..T+16 → the DONE edge T+17 updates the commands.
- cmd_valid is high in the cycle following edge T+17, i.e. 17 cycles after acceptance.
- busy rises in the cycle after T and falls after DONE unless chaining.
- Throughput: one frame per 17 cycles when chained.
- Reset values: motor_1..4_cmd = 0, cmd_valid = 0, busy = 0, overrun = 0, state IDLE, pending cleared, step counter 0.
- Reset mid-MIX or in DONE aborts the frame:
  - No cmd_valid is produced.
  - Outputs are 0 in the cycle after the reset edge.
  - The pending frame is discarded.
- frame_valid coincident with rst is ignored.

## Structure
- Package mix_pkg holds:
  - the state enum (IDLE, MIX, DONE)
  - ACC_W = 11
  - a 4×3 sign-matrix constant MIX_SIGN[motor][axis]
  - motor index constants
- Sub-module offset_mix_alu: combinational ±add of the sign-extended operand into acc, plus clamp and arm gating. The scheduler owns the FSM, counter, snapshots, pending buffer and output registers.

## Test plan
- Zero-attitude baseline: throttle=100, P=R=Y=0, armed=1 → all cmds=100, cmd_valid exactly 17 cycles after acceptance, busy high for 17 cycles.
- Pitch mixing: throttle=100, P=+20, R=Y=0 → M1=M2=120, M3=M4=80.
- Saturation: throttle=240, P=+127, R=+127, Y=−128 → M1=250 (622 clamped), M2=112, M3=114, M4=112.
- Low clamp and disarm:
  - throttle=0, P=−50 → M1=M2=10, M3=M4=50.
  - The same frame with armed=0 → all cmds 0.
- Back-to-back: frames A at cycle 0, B at 5, C at 9:
  - overrun pulses at cycle 9.
  - A's outputs are followed by C's outputs 17 cycles later.
  - B never appears.
- Reset at the 8th MIX cycle: no cmd_valid, outputs 0 and busy low the next cycle. A fresh frame afterwards completes normally in 17 cycles.
